// File: rtl/coffee_dispenser.sv
// Coffee dispenser: brew sequencer (cup drop, then water + flavour valves
// for a recipe-dependent time) plus an independent change-token payout
// engine talking to a coin hopper over a req/ack handshake.
module coffee_dispenser #(
  parameter int TIMER_W    = 16,
  parameter int CUP_CYCLES = 4,
  parameter int BREW_PC    = 8,
  parameter int BREW_HC    = 12,
  parameter int BREW_CC    = 16,
  parameter int EJECT_GAP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dispense,
  input  logic [2:0] coffee_select,
  input  logic [7:0] change_tokens,
  input  logic       coin_eject_ack,
  output logic       dispense_done,
  output logic       cup_drop,
  output logic       valve_water,
  output logic [1:0] flavor_sel,
  output logic       busy,
  output logic       coin_eject,
  output logic [7:0] pending_change
);

  typedef enum logic [2:0] {IDLE, CUP, BREW, DONE, RELEASE} brew_t;
  typedef enum logic [1:0] {EJ_IDLE, EJ_REQ, EJ_GAP} ej_t;

  brew_t              state, state_nx;
  logic [TIMER_W-1:0] timer, timer_nx;
  logic [1:0]         sel_q, sel_nx;

  ej_t                ej, ej_nx;
  logic [TIMER_W-1:0] gap, gap_nx;
  logic               dec;
  logic [9:0]         pend_sum;
  logic [7:0]         pend_nx;

  // Brew length in cycles for a latched recipe.
  function automatic logic [TIMER_W-1:0] brew_len(input logic [1:0] s);
    case (s)
      2'd1:    return TIMER_W'(BREW_PC);
      2'd2:    return TIMER_W'(BREW_HC);
      default: return TIMER_W'(BREW_CC);
    endcase
  endfunction

  // Brew FSM next state; the timer counts down to 0 inside CUP and BREW.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    sel_nx   = sel_q;
    case (state)
      IDLE: begin
        if (dispense && (coffee_select inside {3'd1, 3'd2, 3'd3})) begin
          sel_nx   = coffee_select[1:0];
          timer_nx = TIMER_W'(CUP_CYCLES - 1);
          state_nx = CUP;
        end
      end
      CUP: begin
        if (timer == '0) begin
          timer_nx = brew_len(sel_q) - TIMER_W'(1);
          state_nx = BREW;
        end else begin
          timer_nx = timer - TIMER_W'(1);
        end
      end
      BREW: begin
        if (timer == '0) state_nx = DONE;
        else             timer_nx = timer - TIMER_W'(1);
      end
      DONE:    state_nx = RELEASE;
      RELEASE: if (!dispense) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Brew state register; outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      sel_q         <= '0;
      cup_drop      <= 1'b0;
      valve_water   <= 1'b0;
      flavor_sel    <= 2'd0;
      dispense_done <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      timer         <= timer_nx;
      sel_q         <= sel_nx;
      cup_drop      <= (state_nx == CUP);
      valve_water   <= (state_nx == BREW);
      flavor_sel    <= (state_nx == BREW) ? sel_nx : 2'd0;
      dispense_done <= (state_nx == DONE);
      busy          <= (state_nx != IDLE);
    end
  end

  // Payout FSM next state. When the gap expires with tokens still owed,
  // EJ_IDLE is passed through in the same cycle so the low time between
  // requests is exactly EJECT_GAP cycles.
  always_comb begin
    ej_nx  = ej;
    gap_nx = gap;
    dec    = 1'b0;
    case (ej)
      EJ_IDLE: if (pending_change != 8'd0) ej_nx = EJ_REQ;
      EJ_REQ: begin
        if (coin_eject_ack) begin
          dec    = 1'b1;
          gap_nx = TIMER_W'(EJECT_GAP - 1);
          ej_nx  = EJ_GAP;
        end
      end
      EJ_GAP: begin
        if (gap == '0) ej_nx = (pending_change != 8'd0) ? EJ_REQ : EJ_IDLE;
        else           gap_nx = gap - TIMER_W'(1);
      end
      default: ej_nx = EJ_IDLE;
    endcase
  end

  // Saturating accumulate of incoming change minus one per acked eject.
  always_comb begin
    pend_sum = {2'b00, pending_change} + {2'b00, change_tokens} - {9'd0, dec};
    pend_nx  = (pend_sum > 10'd255) ? 8'd255 : pend_sum[7:0];
  end

  // Payout state register and registered hopper request.
  always_ff @(posedge clk) begin
    if (reset) begin
      ej             <= EJ_IDLE;
      gap            <= '0;
      pending_change <= 8'd0;
      coin_eject     <= 1'b0;
    end else begin
      ej             <= ej_nx;
      gap            <= gap_nx;
      pending_change <= pend_nx;
      coin_eject     <= (ej_nx == EJ_REQ);
    end
  end

endmodule

// File: tb/tb_coffee_dispenser.sv
// Scoreboard bench for coffee_dispenser: stimulus pushes expected brew and
// eject records; a monitor sampling after each rising edge pops and checks.
module tb_coffee_dispenser;
  localparam int CUP = 4, PC = 8, HC = 12, CC = 16, GAP = 2;

  logic       clk = 1'b0, reset = 1'b1, dispense = 1'b0, coin_eject_ack = 1'b0;
  logic [2:0] coffee_select = 3'd0;
  logic [7:0] change_tokens = 8'd0;
  logic       dispense_done, cup_drop, valve_water, busy, coin_eject;
  logic [1:0] flavor_sel;
  logic [7:0] pending_change;

  coffee_dispenser #(.TIMER_W(16), .CUP_CYCLES(CUP), .BREW_PC(PC), .BREW_HC(HC),
                     .BREW_CC(CC), .EJECT_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .dispense(dispense), .coffee_select(coffee_select),
    .change_tokens(change_tokens), .coin_eject_ack(coin_eject_ack),
    .dispense_done(dispense_done), .cup_drop(cup_drop), .valve_water(valve_water),
    .flavor_sel(flavor_sel), .busy(busy), .coin_eject(coin_eject),
    .pending_change(pending_change));

  always #5 clk = ~clk;

  typedef struct { int done_cyc; int cup; int brew; int flav; } brew_exp_t;
  typedef struct { int pend; int gap; } coin_exp_t;
  brew_exp_t bq[$];
  coin_exp_t cq[$];

  int tests = 0, fails = 0, cyc = 0;
  bit ack_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({dispense_done, cup_drop, valve_water, flavor_sel, busy, coin_eject, pending_change});
  endfunction

  // Hopper model: acks one cycle after seeing a request.
  initial forever begin
    @(negedge clk);
    coin_eject_ack = ack_en && coin_eject;
  end

  // Monitor / scoreboard.
  int cup_cnt = 0, brew_cnt = 0, flav_bad = 0, low_run = 1000;
  logic prev_coin = 1'b0;
  brew_exp_t be;
  coin_exp_t ce;
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (reset) begin
      cup_cnt = 0; brew_cnt = 0; flav_bad = 0; low_run = 1000; prev_coin = 1'b0;
    end else begin
      if (cup_drop) cup_cnt++;
      if (valve_water) begin
        brew_cnt++;
        if (bq.size() == 0 || int'(flavor_sel) != bq[0].flav) flav_bad++;
      end else if (flavor_sel != 2'd0) flav_bad++;
      if (dispense_done) begin
        if (bq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          be = bq.pop_front();
          chk("done_cycle", cyc, be.done_cyc);
          chk("cup_cycles", cup_cnt, be.cup);
          chk("brew_cycles", brew_cnt, be.brew);
          chk("flavor_errors", flav_bad, 0);
        end
        cup_cnt = 0; brew_cnt = 0; flav_bad = 0;
      end
      if (coin_eject && !prev_coin) begin
        if (cq.size() == 0) chk("unexpected_eject", 1, 0);
        else begin
          ce = cq.pop_front();
          chk("eject_pending", int'(pending_change), ce.pend);
          if (ce.gap > 0) chk("eject_gap", low_run, ce.gap);
        end
      end
      low_run   = coin_eject ? 0 : low_run + 1;
      prev_coin = coin_eject;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_brew(input int sel, input int blen);
    bq.push_back('{cyc + 1 + CUP + blen, CUP, blen, sel});
    dispense      = 1'b1;
    coffee_select = 3'(sel);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!dispense_done && n < 100) begin tick(1); n++; end
    if (n >= 100) chk(name, 0, 1);
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((pending_change != 0 || coin_eject) && n < 200) begin tick(1); n++; end
    chk(name, int'(pending_change), 0);
  endtask

  initial begin
    // Reset defaults, plain brew
    tick(2);
    chk("reset_outputs", all_outs(), 0);
    reset = 1'b0;
    tick(1);
    start_brew(1, PC);
    wait_done("plain_done_timeout");
    tick(3);
    chk("release_busy", int'(busy), 1);
    chk("release_no_cup", int'(cup_drop), 0);
    dispense = 1'b0;
    tick(1);
    chk("release_to_idle", int'(busy), 0);

    // Coconut brew with a select glitch and a held dispense
    tick(1);
    start_brew(3, CC);
    tick(8);
    coffee_select = 3'd1;
    wait_done("coconut_done_timeout");
    tick(5);
    chk("held_dispense_busy", int'(busy), 1);
    chk("held_dispense_no_restart", int'({cup_drop, valve_water}), 0);
    dispense = 1'b0;
    tick(2);

    // Invalid select
    dispense = 1'b1;
    coffee_select = 3'd0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) coffee_select = 3'd5;
      tick(1);
      chk("invalid_select_idle", int'({busy, cup_drop, dispense_done}), 0);
    end
    dispense = 1'b0;
    tick(1);

    // Change payout of 3 tokens
    ack_en = 1'b1;
    cq.push_back('{3, 0}); cq.push_back('{2, GAP}); cq.push_back('{1, GAP});
    change_tokens = 8'd3;
    tick(1);
    change_tokens = 8'd0;
    chk("payout_loaded", int'(pending_change), 3);
    wait_drained("payout_drained");

    // Accumulate during the ack cycle
    tick(3);
    cq.push_back('{1, 0}); cq.push_back('{2, GAP}); cq.push_back('{1, GAP});
    change_tokens = 8'd1;
    tick(1);
    change_tokens = 8'd0;
    begin
      int n = 0;
      while (!coin_eject && n < 50) begin tick(1); n++; end
      if (n >= 50) chk("accum_req_timeout", 0, 1);
    end
    change_tokens = 8'd2;
    tick(1);
    change_tokens = 8'd0;
    chk("accum_in_ack", int'(pending_change), 2);
    wait_drained("accum_drained");

    // Saturation with no hopper acks
    tick(3);
    ack_en = 1'b0;
    cq.push_back('{254, 0});
    change_tokens = 8'd200;
    tick(1);
    change_tokens = 8'd54;
    tick(1);
    chk("pend_254", int'(pending_change), 254);
    change_tokens = 8'd5;
    tick(1);
    change_tokens = 8'd0;
    chk("pend_saturate", int'(pending_change), 255);
    tick(1);
    chk("pend_hold_no_ack", int'(pending_change), 255);
    reset = 1'b1;
    tick(2);
    chk("reset_clears_pending", all_outs(), 0);
    reset = 1'b0;
    tick(1);

    // Reset mid-brew with change owed
    cq.push_back('{4, 0});
    change_tokens = 8'd4;
    tick(1);
    change_tokens = 8'd0;
    dispense = 1'b1;
    coffee_select = 3'd2;
    begin
      int n = 0;
      while (!valve_water && n < 50) begin tick(1); n++; end
      if (n >= 50) chk("brew_start_timeout", 0, 1);
    end
    tick(2);
    chk("pre_reset_pending", int'(pending_change), 4);
    chk("pre_reset_valve", int'(valve_water), 1);
    reset = 1'b1;
    tick(1);
    chk("reset_midbrew", all_outs(), 0);
    reset = 1'b0;
    dispense = 1'b0;
    tick(1);
    start_brew(2, HC);
    wait_done("post_reset_done_timeout");
    dispense = 1'b0;
    tick(3);
    chk("post_reset_idle", int'(busy), 0);

    chk("brew_queue_empty", bq.size(), 0);
    chk("coin_queue_empty", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/coffee_dispenser.md
Name: coffee_dispenser

Overview:
Downstream stage of the vending controller. Consumes dispense, coffee_select and change_tokens, and sequences the physical brew: cup drop, then water plus flavour valves for a recipe-dependent time. Returns a single-cycle dispense_done to the controller. Independently pays out accumulated change tokens to a coin hopper over a req/ack handshake.

Parameters:
TIMER_W, 16, width of the brew/cup/gap down-counter
CUP_CYCLES, 4, cycles cup_drop is held high
BREW_PC, 8, brew cycles for plain coffee (select 1)
BREW_HC, 12, brew cycles for hazelnut coffee (select 2)
BREW_CC, 16, brew cycles for coconut coffee (select 3)
EJECT_GAP, 2, idle cycles between consecutive coin ejects

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
dispense  input  1  brew request level from the vending controller
coffee_select  input  3  recipe: 1 plain, 2 hazelnut, 3 coconut; other values invalid
change_tokens  input  8  change amount; nonzero for a cycle means "add to payout"
coin_eject_ack  input  1  hopper confirms one token ejected
dispense_done  output  1  one-cycle pulse, brew finished
cup_drop  output  1  cup actuator
valve_water  output  1  hot water valve
flavor_sel  output  2  flavour valve select, 0 = none, else latched recipe
busy  output  1  brew FSM not in IDLE
coin_eject  output  1  request to hopper to eject one token
pending_change  output  8  tokens still owed

Behaviour:
- Reset: all outputs 0. Both FSMs go to idle, the timer is 0 and the pending count is 0. Reset mid-brew or mid-eject aborts immediately; owed change is discarded.
- All outputs are registered. Brew FSM states: IDLE, CUP, BREW, DONE, RELEASE.
- IDLE:
  - If dispense=1 and coffee_select is in 1..3: latch the select, load timer=CUP_CYCLES-1, and go to CUP next cycle.
  - If dispense=1 with an invalid select: stay in IDLE and drive no outputs.
- CUP:
  - cup_drop=1 for exactly CUP_CYCLES cycles.
  - Then go to BREW with timer loaded with the recipe brew count minus 1.
- BREW:
  - valve_water=1 and flavor_sel=latched select, for exactly BREW_x cycles.
  - Then go to DONE.
- DONE:
  - dispense_done=1 for exactly one cycle, then go to RELEASE.
- RELEASE:
  - Wait until dispense=0, then return to IDLE.
  - A dispense still high in RELEASE never starts a second brew.
- Changes on coffee_select after acceptance are ignored. Dropping dispense mid-brew does not abort.
- busy=1 in every state except IDLE.
- Latency: dispense sampled high at edge N gives cup_drop high from N+1. dispense_done is high at cycle N+1+CUP_CYCLES+BREW_x.
- Payout FSM states: EJ_IDLE, EJ_REQ, EJ_GAP. It runs concurrently with the brew FSM.
- pending_change accumulation:
  - Every cycle, pending_change += change_tokens, saturating at 255.
  - A simultaneous add and decrement gives pending + change - 1, saturated.
- EJ_IDLE: if pending_change>0, assert coin_eject and go to EJ_REQ.
- EJ_REQ:
  - Hold coin_eject=1 until coin_eject_ack=1.
  - On ack: decrement pending, drop coin_eject the next cycle, load gap timer, go to EJ_GAP.
- EJ_GAP: hold EJECT_GAP cycles with coin_eject=0, then return to EJ_IDLE.
- coin_eject_ack while not in EJ_REQ is ignored.

Test Plan:
- Reset defaults, plain brew: reset 2 cycles, then dispense=1, select=1.
  - Outputs are all 0 during reset.
  - cup_drop is high for 4 cycles, then valve_water=1 and flavor_sel=1 for 8 cycles.
  - dispense_done pulses exactly at cycle 13 after acceptance.
  - The FSM stays in RELEASE until dispense drops.
- Coconut brew with a select glitch: select=3 accepted, select changed to 1 mid-brew.
  - flavor_sel stays 3 for 16 cycles.
  - dispense_done pulses once. A held dispense does not restart the brew.
- Invalid select: dispense=1, select=0, then select=5, for 10 cycles.
  - busy, cup_drop and dispense_done stay 0 throughout.
- Change payout: change_tokens=3 for one cycle, hopper acks 1 cycle after each request.
  - Exactly 3 coin_eject pulses, separated by 2-cycle gaps.
  - pending_change steps 3→2→1→0.
- Accumulate during payout: change_tokens=2 arrives in the ack cycle of a payout with pending=1.
  - pending becomes 2, and ejection continues to 0.
  - With pending=254 and change_tokens=5, pending saturates at 255.
- Reset mid-operation: assert reset during BREW with pending=4.
  - Next cycle all outputs are 0, pending=0 and the FSM is in IDLE.
  - A new dispense after reset runs a full brew.
